// File: rtl/lsk_uplink_receiver_if.sv
// Receiver-side bundle: comparator input, enable, and the valid/ready byte port.
interface lsk_uplink_receiver_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx_en;
  logic                 lsk_in;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_en, lsk_in, rx_ready,
    input  rx_data, rx_valid, parity_err, frame_err, overrun, busy
  );

  modport slave (
    input  rx_en, lsk_in, rx_ready,
    output rx_data, rx_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/lsk_uplink_receiver.sv
// Reader-side LSK uplink demodulator: synchronizes the coil-load comparator,
// recovers start/data/parity/stop framed bytes and presents them through a
// valid/ready holding register with parity, framing and overrun flags.
module lsk_uplink_receiver #(
  parameter int unsigned BIT_CYCLES = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input logic                 clk,
  input logic                 rst,
  lsk_uplink_receiver_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(BIT_CYCLES);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;

  state_t               state, state_next;
  logic                 s_meta, s_in, s_prev;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 half_hit, full_hit;
  logic                 cnt_clr, data_cap, par_cap, deliver, stop_bad;

  assign half_hit = (cnt == HALF_LAST);
  assign full_hit = (cnt == FULL_LAST);
  assign bus.busy = (state != IDLE);

  // Two-flop synchronizer plus one-cycle delayed copy for rising-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta <= 1'b0;
      s_in   <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      s_meta <= bus.lsk_in;
      s_in   <= s_meta;
      s_prev <= s_in;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and per-cycle sampling strobes; rx_en low overrides everything.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    data_cap   = 1'b0;
    par_cap    = 1'b0;
    deliver    = 1'b0;
    stop_bad   = 1'b0;
    if (!bus.rx_en) begin
      state_next = IDLE;
      cnt_clr    = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_clr = 1'b1;
          if (s_in && !s_prev) state_next = START;
        end
        START: begin
          if (half_hit) begin
            cnt_clr    = 1'b1;
            state_next = s_in ? DATA : IDLE;
          end
        end
        DATA: begin
          if (full_hit) begin
            cnt_clr  = 1'b1;
            data_cap = 1'b1;
            if (idx == IDX_LAST) state_next = PARITY;
          end
        end
        PARITY: begin
          if (full_hit) begin
            cnt_clr    = 1'b1;
            par_cap    = 1'b1;
            state_next = STOP;
          end
        end
        STOP: begin
          if (full_hit) begin
            cnt_clr = 1'b1;
            if (s_in) begin
              stop_bad   = 1'b1;
              state_next = WAIT_IDLE;
            end else begin
              deliver    = 1'b1;
              state_next = IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          cnt_clr = 1'b1;
          if (!s_in) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Bit-cell counter and data bit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (data_cap)           idx <= idx + 1'b1;
      else if (state != DATA) idx <= '0;
    end
  end

  // Payload and parity capture at the bit-cell sample points.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (data_cap) shreg[idx] <= s_in;
      if (par_cap)  par_bit    <= s_in;
    end
  end

  // Holding register, handshake and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rx_data    <= '0;
      bus.rx_valid   <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.frame_err <= stop_bad;
      if (deliver) begin
        bus.rx_data    <= shreg;
        bus.parity_err <= (^shreg) ^ par_bit;
        bus.rx_valid   <= 1'b1;
      end else if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
      // Delivery is impossible with rx_en low, so the clear cannot race a set.
      if (!bus.rx_en)
        bus.overrun <= 1'b0;
      else if (deliver && bus.rx_valid && !bus.rx_ready)
        bus.overrun <= 1'b1;
    end
  end

endmodule
